// File: rtl/data_mem_sequencer.sv
// ---------------------------------------------------------------------------
// data_mem_sequencer
//
// Sequences 32-bit word and 8-bit byte loads/stores from the single-cycle
// datapath onto a byte-wide, synchronous-read data RAM, one byte per cycle.
// While a transfer is in flight, stall freezes the PC and the register-file
// write. done pulses for one cycle when the instruction may retire.
//
// Optional feature (macro DMEM_ALIGN_CHECK_EN):
//   Adds a misalign output. A word request with addr[1:0] != 0 skips the RAM
//   entirely, goes straight to DONE, and raises misalign for that cycle.
//   When the macro is undefined, misaligned word requests are force-aligned.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-low reset
//   req_valid  in   memory instruction present in execute
//   req_write  in   1 = store, 0 = load
//   req_byte   in   1 = byte access, 0 = word access
//   addr       in   byte address (ALUResult); bits above ADDR_W-1 are ignored
//   wdata      in   store data; a byte store uses wdata[7:0]
//   stall      out  hold PC/register file while high
//   rdata      out  load result; byte loads are zero-extended
//   done       out  one-cycle retire pulse
//   misalign   out  (DMEM_ALIGN_CHECK_EN only) misaligned word request rejected
//   ram_addr   out  RAM byte address
//   ram_wdata  out  RAM write byte
//   ram_we     out  RAM write enable
//   ram_rdata  in   RAM read byte, valid the cycle after ram_addr
// ---------------------------------------------------------------------------
module data_mem_sequencer #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              done,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic              misalign,
`endif
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD      = 3'd2,
        RD_LAST = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base;      // latched start address of the transfer
    logic [31:0]       wbuf;      // latched store data
    logic              is_byte;   // latched access size
    logic [1:0]        beat;      // byte index currently on the RAM port
    logic [1:0]        prev_beat;
    logic              last_beat;
    logic              take_req;  // request accepted into the RAM sequence

    // Address bits above the RAM size wrap and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr[31:ADDR_W]};

`ifdef DMEM_ALIGN_CHECK_EN
    logic reject_req;
    assign reject_req = req_valid && !req_byte && (addr[1:0] != 2'b00);
`endif

    // A byte access has a single beat, so beat 0 is already the last one.
    assign last_beat = is_byte || (beat == 2'd3);
    assign prev_beat = beat - 2'd1;

    // The beat counter stops on the last beat instead of running past it, so
    // ram_addr/ram_wdata keep showing the final byte in IDLE and DONE.
    assign ram_addr  = base + {{(ADDR_W-2){1'b0}}, beat};
    assign ram_wdata = wbuf[{beat, 3'b000} +: 8];

    always_comb begin
        take_req = (state == IDLE) && req_valid;
`ifdef DMEM_ALIGN_CHECK_EN
        take_req = take_req && !reject_req;
`endif
    end

    // NOTE: state-holding registers use non-blocking assignments so every
    // flop samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        done     = 1'b0;
        ram_we   = 1'b0;
        unique case (state)
            IDLE: begin
                stall = req_valid;
                if (req_valid) begin
`ifdef DMEM_ALIGN_CHECK_EN
                    if (reject_req) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = req_write ? WR : RD;
                    end
`else
                    state_nx = req_write ? WR : RD;
`endif
                end
            end
            WR: begin
                stall  = 1'b1;
                ram_we = 1'b1;
                if (last_beat) begin
                    state_nx = DONE;
                end
            end
            RD: begin
                stall = 1'b1;
                if (last_beat) begin
                    state_nx = RD_LAST;
                end
            end
            RD_LAST: begin
                stall    = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                // A req_valid seen here belongs to the retiring instruction.
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // stall is combinational from req_valid, so it must be gated by the
        // reset itself to stay low while rst is held.
        if (!rst) begin
            stall = 1'b0;
        end
    end

    // Datapath registers: request latches, beat counter and load assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base    <= '0;
            wbuf    <= '0;
            is_byte <= 1'b0;
            beat    <= 2'd0;
            rdata   <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
            misalign <= 1'b0;
`endif
        end else begin
`ifdef DMEM_ALIGN_CHECK_EN
            // Registered so it is high exactly during the DONE that follows
            // a rejected request.
            misalign <= (state == IDLE) && reject_req;
`endif
            case (state)
                IDLE: begin
                    if (take_req) begin
                        base    <= req_byte ? addr[ADDR_W-1:0]
                                            : {addr[ADDR_W-1:2], 2'b00};
                        wbuf    <= wdata;
                        is_byte <= req_byte;
                        beat    <= 2'd0;
                    end
                end
                WR: begin
                    if (!last_beat) begin
                        beat <= beat + 2'd1;
                    end
                end
                RD: begin
                    // RAM data lags the address by one cycle, so this cycle's
                    // ram_rdata belongs to the previous beat.
                    if (beat != 2'd0) begin
                        rdata[{prev_beat, 3'b000} +: 8] <= ram_rdata;
                    end
                    if (!last_beat) begin
                        beat <= beat + 2'd1;
                    end
                end
                RD_LAST: begin
                    rdata[{beat, 3'b000} +: 8] <= ram_rdata;
                    if (is_byte) begin
                        rdata[31:8] <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_data_mem_sequencer
//
// Directed bench for data_mem_sequencer with ADDR_W = 10. A behavioural
// byte-wide synchronous-read RAM sits on the RAM port; every write it
// accepts is logged so address/data sequences can be compared against
// hand-computed expectations. Build with +define+DMEM_ALIGN_CHECK_EN to
// exercise the misaligned-word rejection instead of force-alignment.
// ---------------------------------------------------------------------------
module tb_data_mem_sequencer;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_write;
    logic              req_byte;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              stall;
    logic [31:0]       rdata;
    logic              done;
`ifdef DMEM_ALIGN_CHECK_EN
    logic              misalign;
`endif
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic [7:0]        ram_rdata;

    int errors = 0;
    int checks = 0;

    data_mem_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_byte  (req_byte),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .rdata     (rdata),
        .done      (done),
`ifdef DMEM_ALIGN_CHECK_EN
        .misalign  (misalign),
`endif
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM plus write log ({addr, data} per accepted write).
    logic [7:0]  mem [0:(1<<ADDR_W)-1];
    logic [17:0] wr_q [$];

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        ram_rdata = 8'h00;
    end

    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_q.push_back({ram_addr, ram_wdata});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [9:0] a, input logic [7:0] d);
        logic [17:0] e;
        e = (idx < wr_q.size()) ? wr_q[idx] : 18'h3ffff;
        check(tag, {14'd0, e}, {14'd0, a, d});
    endtask

    // Issues one request and follows it to its done pulse. When garbage is
    // set, req_* is scrambled (with req_valid high) after the accept cycle.
    task automatic run_op(input logic wr, input logic byt, input logic [31:0] a,
                          input logic [31:0] d, input bit garbage,
                          output logic [31:0] rd, output int stalls,
                          output int total, output logic mis);
        logic seen;
        seen   = 1'b0;
        stalls = 0;
        total  = 0;
        rd     = 'x;
        mis    = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_byte = byt; addr = a; wdata = d;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++;
            if (stall) stalls++;
            if (done) begin
                rd = rdata;
`ifdef DMEM_ALIGN_CHECK_EN
                mis = misalign;
`endif
                req_valid = 1'b0;
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (garbage) begin
                req_valid = 1'b1; req_write = ~wr; req_byte = ~byt;
                addr = $urandom; wdata = $urandom;
            end else begin
                req_valid = 1'b0;
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask

    logic [31:0] rd;
    int          st, tot;
    logic        mis;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        #1;
        // Reset state, with req_valid high to show stall is forced low.
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_we", {31'd0, ram_we}, 32'd0);
        check("rst_addr", {22'd0, ram_addr}, 32'd0);
        check("rst_wdata", {24'd0, ram_wdata}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;

        // Word store 0xDEADBEEF to 0x10.
        wr_q.delete();
        run_op(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, rd, st, tot, mis);
        check("ws_stall", st, 5);
        check("ws_total", tot, 6);
        check("ws_nwr", wr_q.size(), 4);
        check_wr("ws_w0", 0, 10'h010, 8'hEF);
        check_wr("ws_w1", 1, 10'h011, 8'hBE);
        check_wr("ws_w2", 2, 10'h012, 8'hAD);
        check_wr("ws_w3", 3, 10'h013, 8'hDE);

        // Word load from 0x10.
        wr_q.delete();
        run_op(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, rd, st, tot, mis);
        check("wl_rdata", rd, 32'hDEADBEEF);
        check("wl_stall", st, 6);
        check("wl_total", tot, 7);
        check("wl_nwr", wr_q.size(), 0);

        // Byte store 0x55 to 0x12 (upper wdata bytes must be ignored).
        wr_q.delete();
        run_op(1'b1, 1'b1, 32'h12, 32'hAABBCC55, 1'b0, rd, st, tot, mis);
        check("bs_stall", st, 2);
        check("bs_total", tot, 3);
        check("bs_nwr", wr_q.size(), 1);
        check_wr("bs_w0", 0, 10'h012, 8'h55);

        // Byte load 0x12: zero-extended over the previous full word.
        run_op(1'b0, 1'b1, 32'h12, 32'h0, 1'b0, rd, st, tot, mis);
        check("bl_rdata", rd, 32'h00000055);
        check("bl_stall", st, 3);
        check("bl_total", tot, 4);

        // Word load 0x10 with req_* scrambled during the transfer.
        wr_q.delete();
        run_op(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, rd, st, tot, mis);
        check("wl2_rdata", rd, 32'hDE55BEEF);
        check("wl2_total", tot, 7);
        check("wl2_nwr", wr_q.size(), 0);

        // Wrap at the top of the RAM.
        run_op(1'b1, 1'b1, 32'h0, 32'h0000007E, 1'b0, rd, st, tot, mis);
        wr_q.delete();
        run_op(1'b1, 1'b1, 32'h3FF, 32'h000000A5, 1'b0, rd, st, tot, mis);
        check_wr("wrap_b", 0, 10'h3FF, 8'hA5);
        wr_q.delete();
        run_op(1'b1, 1'b0, 32'h3FC, 32'h01020304, 1'b0, rd, st, tot, mis);
        check("wrap_nwr", wr_q.size(), 4);
        check_wr("wrap_w0", 0, 10'h3FC, 8'h04);
        check_wr("wrap_w1", 1, 10'h3FD, 8'h03);
        check_wr("wrap_w2", 2, 10'h3FE, 8'h02);
        check_wr("wrap_w3", 3, 10'h3FF, 8'h01);
        run_op(1'b0, 1'b1, 32'h400, 32'h0, 1'b0, rd, st, tot, mis);
        check("wrap_bl400", rd, 32'h0000007E);
        run_op(1'b0, 1'b1, 32'h3FF, 32'h0, 1'b0, rd, st, tot, mis);
        check("wrap_bl3ff", rd, 32'h00000001);

        // Reset during the 2nd WR beat of a word store to 0x20.
        wr_q.delete();
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0;
        addr = 32'h20; wdata = 32'h11223344;
        @(posedge clk); #1;           // WR beat 0
        req_valid = 1'b0;
        @(posedge clk); #1;           // WR beat 1
        check("mid_we_pre", {31'd0, ram_we}, 32'd1);
        check("mid_addr_pre", {22'd0, ram_addr}, 32'h21);
        rst = 1'b0; req_valid = 1'b1;
        #1;
        check("mid_we_async", {31'd0, ram_we}, 32'd0);
        check("mid_stall_async", {31'd0, stall}, 32'd0);
        repeat (3) @(negedge clk);
        check("mid_done", {31'd0, done}, 32'd0);
        check("mid_rdata", rdata, 32'd0);
        req_valid = 1'b0;
        rst = 1'b1;
        check("mid_nwr", wr_q.size(), 1);
        check_wr("mid_w0", 0, 10'h020, 8'h44);
        run_op(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, rd, st, tot, mis);
        check("mid_after_rdata", rd, 32'h00000044);
        check("mid_after_total", tot, 7);

        // Misaligned word load from 0x13.
        wr_q.delete();
        run_op(1'b0, 1'b0, 32'h13, 32'h0, 1'b0, rd, st, tot, mis);
`ifdef DMEM_ALIGN_CHECK_EN
        check("mis_flag", {31'd0, mis}, 32'd1);
        check("mis_rdata", rd, 32'h00000044);
        check("mis_total", tot, 2);
        @(negedge clk);
        check("mis_clear", {31'd0, misalign}, 32'd0);
`else
        check("mis_rdata", rd, 32'hDE55BEEF);
        check("mis_total", tot, 7);
`endif
        check("mis_nwr", wr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
